// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix scan controller.
package led_matrix_pkg;

    typedef enum logic [1:0] {
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } scan_state_e;

    // Length of one shift burst: both chains are padded to the longer side.
    function automatic int shift_len(input int rows, input int cols);
        return (rows > cols) ? rows : cols;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Scan enable: one-cycle tick every DIV+1 clocks, phase counted from reset release.
module tick_div
    import led_matrix_pkg::*;
#(
    parameter int DIV = 499
) (
    input  logic CLK1_50,
    input  logic CLR,
    output logic tick
);

    localparam int CW = (DIV < 1) ? 1 : $clog2(DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Terminal-count compare and wrap of the period counter.
    always_comb begin
        tick  = (cnt_q == CW'(DIV));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Period counter register.
    always_ff @(posedge CLK1_50) begin
        if (CLR) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Double-buffered LED matrix scanner driving SER/SRCLK/RCLK shift-register chains.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// SHIFT_LO | SRCLK low, bit b of current row presented on ser_data/ser_row
// SHIFT_HI | SRCLK high, bit b clocked into both chains
// LATCH    | RCLK high for one tick, shifted row transferred to the outputs
module led_matrix_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int ROWS           = 16,
    parameter int COLS           = 16,
    parameter int DIV            = 499,
    parameter int ROW_ACTIVE_LOW = 0,
    parameter int COL_ACTIVE_LOW = 0
) (
    input  logic                    CLK1_50,
    input  logic                    CLR,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    frame_done,
    output logic                    ser_data,
    output logic                    ser_row,
    output logic                    SRCLK,
    output logic                    RCLK
);

    localparam int   L       = shift_len(ROWS, COLS);
    localparam int   RW      = $clog2(ROWS);
    localparam int   BW      = $clog2(L);
    localparam int   CW      = $clog2(COLS);
    localparam int   AW      = $clog2(2 * ROWS);
    localparam logic ROW_INV = (ROW_ACTIVE_LOW != 0);
    localparam logic COL_INV = (COL_ACTIVE_LOW != 0);

    // The pixel read happens in the clock after the SHIFT_LO entry tick, so the
    // next tick (SRCLK rise) must be at least one clock later.
    if (DIV < 1) begin : g_bad_div
        $error("led_matrix_scan_ctrl: DIV must be >= 1");
    end
    if (ROWS < 2 || COLS < 2) begin : g_bad_size
        $error("led_matrix_scan_ctrl: ROWS and COLS must be >= 2");
    end

    logic tick;

    tick_div #(.DIV(DIV)) u_tick_div (
        .CLK1_50 (CLK1_50),
        .CLR     (CLR),
        .tick    (tick)
    );

    // Buffer 0 occupies entries 0..ROWS-1, buffer 1 entries ROWS..2*ROWS-1.
    logic [COLS-1:0] buf_mem [2*ROWS];

    scan_state_e   state_q, state_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [RW-1:0] row_q, row_d;
    logic          front_q, front_d;
    logic          valid_q, valid_d;
    logic          pend_q, pend_d;
    logic          load_q, load_d;
    logic          srclk_q, srclk_d;
    logic          rclk_q, rclk_d;
    logic          ser_data_q, ser_data_d;
    logic          ser_row_q, ser_row_d;
    logic          swap_ack_q, swap_ack_d;
    logic          frame_done_q, frame_done_d;

    logic          wr_ok;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [COLS-1:0] rd_word;
    logic [CW-1:0] col_idx;

    // Buffer addressing: writes go to the back half, reads to the front half.
    always_comb begin
        wr_ok   = (int'(wr_row) < ROWS);
        wr_addr = AW'(int'(!front_q) * ROWS + int'(wr_row));
        rd_addr = AW'(int'(front_q) * ROWS + int'(row_q));
        rd_word = buf_mem[rd_addr];
        col_idx = CW'(bit_q);
    end

    // Back-buffer write port; a write in the swap cycle uses the pre-toggle back side.
    always_ff @(posedge CLK1_50) begin
        if (!CLR && wr_en && wr_ok) buf_mem[wr_addr] <= wr_data;
    end

    // Scan sequencing, frame end and swap decision.
    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        row_d        = row_q;
        front_d      = front_q;
        valid_d      = valid_q;
        pend_d       = pend_q | swap_req;
        load_d       = 1'b0;
        srclk_d      = srclk_q;
        rclk_d       = rclk_q;
        swap_ack_d   = 1'b0;
        frame_done_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                SHIFT_LO: begin
                    state_d = SHIFT_HI;
                    srclk_d = 1'b1;
                end
                SHIFT_HI: begin
                    srclk_d = 1'b0;
                    if (bit_q == '0) begin
                        state_d = LATCH;
                        rclk_d  = 1'b1;
                    end else begin
                        state_d = SHIFT_LO;
                        bit_d   = bit_q - 1'b1;
                        load_d  = 1'b1;
                    end
                end
                LATCH: begin
                    rclk_d  = 1'b0;
                    state_d = SHIFT_LO;
                    bit_d   = BW'(L - 1);
                    load_d  = 1'b1;
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                        if (pend_d) begin
                            front_d    = !front_q;
                            valid_d    = 1'b1;
                            swap_ack_d = 1'b1;
                            pend_d     = 1'b0;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
                default: state_d = SHIFT_LO;
            endcase
        end
    end

    // Serial bit values, refreshed one clock after entering SHIFT_LO so the
    // freshly swapped front buffer and same-edge writes are already visible.
    always_comb begin
        ser_data_d = ser_data_q;
        ser_row_d  = ser_row_q;
        if (load_q) begin
            ser_row_d  = ROW_INV ^ (int'(bit_q) == int'(row_q));
            ser_data_d = COL_INV ^ (valid_q && (int'(bit_q) < COLS) && rd_word[col_idx]);
        end
    end

    // State and output registers; load_q resets high to seed the first SHIFT_LO bit.
    always_ff @(posedge CLK1_50) begin
        if (CLR) begin
            state_q      <= SHIFT_LO;
            bit_q        <= BW'(L - 1);
            row_q        <= '0;
            front_q      <= 1'b0;
            valid_q      <= 1'b0;
            pend_q       <= 1'b0;
            load_q       <= 1'b1;
            srclk_q      <= 1'b0;
            rclk_q       <= 1'b0;
            ser_data_q   <= 1'b0;
            ser_row_q    <= 1'b0;
            swap_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            row_q        <= row_d;
            front_q      <= front_d;
            valid_q      <= valid_d;
            pend_q       <= pend_d;
            load_q       <= load_d;
            srclk_q      <= srclk_d;
            rclk_q       <= rclk_d;
            ser_data_q   <= ser_data_d;
            ser_row_q    <= ser_row_d;
            swap_ack_q   <= swap_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign SRCLK      = srclk_q;
    assign RCLK       = rclk_q;
    assign ser_data   = ser_data_q;
    assign ser_row    = ser_row_q;
    assign swap_ack   = swap_ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl: 4x4 instance against a scoreboard model,
// plus a 4x6 active-low-row instance checked for padding and row time.
module tb_led_matrix_scan_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DIV  = 1;
    localparam int L    = 4;
    localparam int R    = 2 * L + 1;
    localparam int FT   = ROWS * R;
    localparam int FCLK = FT * (DIV + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 4x4 instance ----------------
    logic       clr = 1'b1, wr_en = 1'b0, swap_req = 1'b0;
    logic [1:0] wr_row = '0;
    logic [3:0] wr_data = '0;
    logic       swap_ack, frame_done, ser_data, ser_row, srclk, rclk;

    led_matrix_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .ROW_ACTIVE_LOW(0), .COL_ACTIVE_LOW(0)
    ) dut (
        .CLK1_50(clk), .CLR(clr), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .swap_req(swap_req), .swap_ack(swap_ack), .frame_done(frame_done),
        .ser_data(ser_data), .ser_row(ser_row), .SRCLK(srclk), .RCLK(rclk)
    );

    // ---------------- 4x6 active-low-row instance ----------------
    logic       clr2 = 1'b1;
    logic       wr_en2 = 1'b0, swap_req2 = 1'b0;
    logic [1:0] wr_row2 = '0;
    logic [5:0] wr_data2 = '0;
    logic       swap_ack2, frame_done2, ser_data2, ser_row2, srclk2, rclk2;

    led_matrix_scan_ctrl #(
        .ROWS(4), .COLS(6), .DIV(DIV), .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(0)
    ) dut2 (
        .CLK1_50(clk), .CLR(clr2), .wr_en(wr_en2), .wr_row(wr_row2), .wr_data(wr_data2),
        .swap_req(swap_req2), .swap_ack(swap_ack2), .frame_done(frame_done2),
        .ser_data(ser_data2), .ser_row(ser_row2), .SRCLK(srclk2), .RCLK(rclk2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard producer ----------------
    typedef struct packed {
        logic [3:0] data;
        logic [3:0] rowsel;
    } latch_t;

    latch_t     lat_q[$];
    logic       fr_q[$];
    logic [3:0] mbuf [2][4];
    logic       mfront = 1'b0, mvalid = 1'b0, mpend = 1'b0;
    int         mcnt = 0, mn = 0;
    int         mrow;
    logic [3:0] mdat, moh;

    always @(posedge clk) begin
        if (clr) begin
            mfront = 1'b0; mvalid = 1'b0; mpend = 1'b0;
            mcnt = 0; mn = 0;
            lat_q.delete();
            fr_q.delete();
        end else begin
            if (wr_en) mbuf[!mfront][wr_row] = wr_data;
            if (swap_req) mpend = 1'b1;
            if (mcnt == DIV) begin
                mcnt = 0;
                mn++;
                if (mn % R == 2 * L) begin
                    mrow = ((mn - 1) % FT) / R;
                    mdat = mvalid ? mbuf[mfront][mrow] : 4'h0;
                    moh  = 4'b0001 << mrow;
                    lat_q.push_back({mdat, moh});
                end
                if (mn % FT == 0) begin
                    fr_q.push_back(mpend);
                    if (mpend) begin
                        mfront = !mfront;
                        mvalid = 1'b1;
                        mpend  = 1'b0;
                    end
                end
            end else begin
                mcnt++;
            end
        end
    end

    // ---------------- monitor / scoreboard consumer (4x4) ----------------
    logic [3:0] sh_d = '0, sh_r = '0;
    logic       srclk_p = 1'b0, rclk_p = 1'b0;
    int         rclk_hi = 0, n_lat = 0;
    latch_t     e_lat;
    logic       e_fr;

    always @(negedge clk) begin
        if (clr) begin
            rclk_hi = 0;
        end else begin
            if (srclk && !srclk_p) begin
                sh_d = {sh_d[2:0], ser_data};
                sh_r = {sh_r[2:0], ser_row};
            end
            if (rclk && !rclk_p) begin
                if (lat_q.size() == 0) begin
                    chk("latch_unexpected", 1, 0);
                end else begin
                    e_lat = lat_q.pop_front();
                    n_lat++;
                    chk("latch_data", sh_d, e_lat.data);
                    chk("latch_row", sh_r, e_lat.rowsel);
                end
            end
            if (rclk) rclk_hi++;
            else if (rclk_p) begin
                chk("rclk_width", rclk_hi, DIV + 1);
                rclk_hi = 0;
            end
            if (frame_done) begin
                if (fr_q.size() == 0) chk("frame_unexpected", 1, 0);
                else begin
                    e_fr = fr_q.pop_front();
                    chk("swap_ack_at_fd", swap_ack, e_fr);
                end
            end else if (swap_ack) begin
                chk("swap_ack_stray", 1, 0);
            end
        end
        srclk_p = srclk;
        rclk_p  = rclk;
    end

    // ---------------- monitor (4x6, active-low rows) ----------------
    logic [5:0] sh2_d = '0, sh2_r = '0;
    logic       srclk2_p = 1'b0, rclk2_p = 1'b0;
    int         r2 = 0, last_rise = -1, cyc = 0;
    logic [3:0] oh2;

    always @(negedge clk) begin
        cyc++;
        if (clr2) begin
            r2 = 0;
            last_rise = -1;
        end else begin
            if (srclk2 && !srclk2_p) begin
                sh2_d = {sh2_d[4:0], ser_data2};
                sh2_r = {sh2_r[4:0], ser_row2};
            end
            if (rclk2 && !rclk2_p) begin
                oh2 = 4'b0001 << r2;
                chk("w2_row", sh2_r, {2'b11, ~oh2});
                chk("w2_data", sh2_d, 6'h00);
                if (last_rise >= 0) chk("w2_row_time", cyc - last_rise, 13 * (DIV + 1));
                last_rise = cyc;
                r2 = (r2 + 1) % 4;
            end
        end
        srclk2_p = srclk2;
        rclk2_p  = rclk2;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [1:0] r, input logic [3:0] d);
        wr_en = 1'b1; wr_row = r; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 4 * FCLK);
        if (!frame_done) chk(tag, 0, 1);
    endtask

    // sel 0 = RCLK, 1 = SRCLK
    task automatic wait_lvl(input int sel, input logic lvl, input string tag);
        int n = 0;
        logic cur;
        cur = (sel == 0) ? rclk : srclk;
        while (cur !== lvl && n < 200) begin
            @(negedge clk);
            n++;
            cur = (sel == 0) ? rclk : srclk;
        end
        if (cur !== lvl) chk(tag, 0, 1);
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int acks;
        repeat (3) @(negedge clk);
        chk("rst_srclk", srclk, 0);
        chk("rst_rclk", rclk, 0);
        chk("rst_ser_data", ser_data, 0);
        chk("rst_ser_row", ser_row, 0);
        chk("rst_swap_ack", swap_ack, 0);
        chk("rst_frame_done", frame_done, 0);
        clr = 1'b0;
        clr2 = 1'b0;

        // Blank frames, then first pattern and mid-frame swap request.
        wait_frame("to_blank1");
        wait_frame("to_blank2");
        wr(2'd0, 4'h1); wr(2'd1, 4'h2); wr(2'd2, 4'h4); wr(2'd3, 4'h8);
        repeat (20) @(negedge clk);
        pulse_swap();
        wait_frame("to_swap1");
        chk("swap1_ack", swap_ack, 1);
        wait_frame("to_a1");

        // Back buffer rewrite must not disturb the displayed pattern.
        wr(2'd0, 4'h1); wr(2'd1, 4'h2); wr(2'd2, 4'hF); wr(2'd3, 4'h8);
        wait_frame("to_a2");
        chk("noswap_ack", swap_ack, 0);
        wait_frame("to_a3");
        repeat (30) @(negedge clk);
        pulse_swap();
        wait_frame("to_swap2");
        chk("swap2_ack", swap_ack, 1);
        wait_frame("to_b1");

        // swap_req only in the frame-end cycle.
        n = 0;
        while (!(mcnt == DIV && (mn + 1) % FT == 0) && n < 2 * FCLK) begin
            @(negedge clk);
            n++;
        end
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        chk("fe_swap_ack", swap_ack, 1);
        chk("fe_frame_done", frame_done, 1);

        // swap_req held for three frames.
        wait_frame("to_hold");
        swap_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 3 * FCLK; i++) begin
            @(negedge clk);
            if (swap_ack) acks++;
        end
        swap_req = 1'b0;
        chk("held_swaps", acks, 3);
        wait_frame("to_pre_clr");

        // Reset in SHIFT_HI of row 2.
        wait_lvl(0, 1'b1, "to_r0_hi"); wait_lvl(0, 1'b0, "to_r0_lo");
        wait_lvl(0, 1'b1, "to_r1_hi"); wait_lvl(0, 1'b0, "to_r1_lo");
        wait_lvl(1, 1'b1, "to_r2_shift_hi");
        clr = 1'b1;
        @(negedge clk);
        chk("clr_srclk", srclk, 0);
        chk("clr_rclk", rclk, 0);
        chk("clr_ser_data", ser_data, 0);
        chk("clr_ser_row", ser_row, 0);
        chk("clr_swap_ack", swap_ack, 0);
        chk("clr_frame_done", frame_done, 0);
        clr = 1'b0;

        // Blanked after reset, then retained memory shown after a new swap.
        wait_frame("to_post1");
        chk("post_clr_noack", swap_ack, 0);
        pulse_swap();
        wait_frame("to_post_swap");
        chk("post_clr_swap", swap_ack, 1);
        wait_frame("to_post2");
        @(negedge clk);

        chk("latch_q_empty", lat_q.size(), 0);
        chk("frame_q_empty", fr_q.size(), 0);
        chk("latches_seen", (n_lat > 60), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
